// File: rtl/fft_sched_pkg.sv
// fft_sched_pkg: shared state, tag type and frame-length helper for the FFT frame scheduler
package fft_sched_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, FLUSH} state_t;

   typedef struct packed {
      logic is_real;
      logic id;
   } tag_t;

   function automatic int frame_len(input int log2n);
      return 1 << log2n;
   endfunction

endpackage

// File: rtl/fft_sched_tagq.sv
// fft_sched_tagq: frame-tag FIFO, preloaded on reset with PRIME non-real tags for the pipeline's priming frames
module fft_sched_tagq
   import fft_sched_pkg::*;
#(
   parameter int PRIME = 1,
   parameter int DEPTH = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic push,
   input  tag_t push_tag,
   input  logic pop,
   output tag_t head,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   tag_t mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic do_push, do_pop;

   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign head = mem[rd_ptr];

   // storage, pointers and occupancy; a pop on an empty queue is ignored
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= AW'(PRIME);
         rd_ptr <= '0;
         count <= (AW+1)'(PRIME);
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_tag;
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/fft_sched.sv
// fft_sched: frame-level round-robin feeder and result tagger for an SDF FFT pipeline (FFT_SCHED_STATS_EN adds frame counters)
module fft_sched
   import fft_sched_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LOG2N = 6,
   parameter int PRIME = 1,
   parameter int TAGQ_DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             s0_valid,
   output logic             s0_ready,
   input  logic [WIDTH-1:0] s0_re,
   input  logic [WIDTH-1:0] s0_im,
   input  logic             s1_valid,
   output logic             s1_ready,
   input  logic [WIDTH-1:0] s1_re,
   input  logic [WIDTH-1:0] s1_im,
   output logic             fft_in_en,
   output logic [WIDTH-1:0] fft_in_re,
   output logic [WIDTH-1:0] fft_in_im,
   input  logic             fft_out_en,
   input  logic [WIDTH-1:0] fft_out_re,
   input  logic [WIDTH-1:0] fft_out_im,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_re,
   output logic [WIDTH-1:0] m_im,
   output logic             m_id,
   output logic             m_last,
   output logic             busy,
   output logic [15:0]      stat_frames0,
   output logic [15:0]      stat_frames1
);

   localparam int N = frame_len(LOG2N);
   localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
   localparam int RW = $clog2(TAGQ_DEPTH + 1);

   state_t state, state_nx;
   logic rr, gid, win, accept, in_last, push, pop, full, empty, head_real;
   logic [LOG2N-1:0] in_cnt, out_cnt;
   logic [RW-1:0] real_cnt;
   tag_t head, push_tag;

   assign push = (accept || state == FLUSH) && in_cnt == '0;
   assign push_tag = '{is_real: state == GRANT, id: gid};
   assign pop = fft_out_en && out_cnt == LAST;
   assign head_real = !empty && head.is_real;
   assign busy = state != IDLE || real_cnt != '0;

   fft_sched_tagq #(.PRIME(PRIME), .DEPTH(TAGQ_DEPTH)) u_tagq (
      .clock(clock),
      .reset(reset),
      .push(push),
      .push_tag(push_tag),
      .pop(pop),
      .head(head),
      .full(full),
      .empty(empty)
   );

   // next state, frame winner and ready decode; only the granted requester sees ready
   always_comb begin
      state_nx = state;
      win = (s0_valid && s1_valid) ? rr : s1_valid;
      s0_ready = state == GRANT && !gid;
      s1_ready = state == GRANT && gid;
      accept = (s0_valid && s0_ready) || (s1_valid && s1_ready);
      in_last = in_cnt == LAST;
      if (state == IDLE && !full)
         state_nx = (s0_valid || s1_valid) ? GRANT : (real_cnt != '0) ? FLUSH : IDLE;
      else if ((accept || state == FLUSH) && in_last)
         state_nx = IDLE;
   end

   // state, grant ownership, input sample count and the registered sample into the pipeline
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         rr <= 1'b0;
         gid <= 1'b0;
         in_cnt <= '0;
         fft_in_en <= 1'b0;
         fft_in_re <= '0;
         fft_in_im <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && state_nx == GRANT) begin
            gid <= win;
            rr <= !win;
         end
         if (accept || state == FLUSH) in_cnt <= in_cnt + LOG2N'(1);
         fft_in_en <= accept || state == FLUSH;
         fft_in_re <= accept ? (gid ? s1_re : s0_re) : '0;
         fft_in_im <= accept ? (gid ? s1_im : s0_im) : '0;
      end
   end

   // queued real-frame count, so flushing continues until every real frame has drained
   always_ff @(posedge clock or posedge reset) begin
      if (reset) real_cnt <= '0;
      else real_cnt <= real_cnt + RW'(push && push_tag.is_real) - RW'(pop && head_real);
   end

   // output sample count and result registers, gated by the head tag of the current output frame
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_cnt <= '0;
         m_valid <= 1'b0;
         m_last <= 1'b0;
         m_id <= 1'b0;
         m_re <= '0;
         m_im <= '0;
      end else begin
         if (fft_out_en) out_cnt <= out_cnt + LOG2N'(1);
         m_valid <= fft_out_en && head_real;
         m_last <= fft_out_en && head_real && out_cnt == LAST;
         m_id <= fft_out_en && head_real && head.id;
         m_re <= (fft_out_en && head_real) ? fft_out_re : '0;
         m_im <= (fft_out_en && head_real) ? fft_out_im : '0;
      end
   end

`ifdef FFT_SCHED_STATS_EN
   // completed grant frames per requester, wrapping at 2^16
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_frames0 <= '0;
         stat_frames1 <= '0;
      end else if (state == GRANT && accept && in_last) begin
         if (gid) stat_frames1 <= stat_frames1 + 16'd1;
         else stat_frames0 <= stat_frames0 + 16'd1;
      end
   end
`else
   assign stat_frames0 = '0;
   assign stat_frames1 = '0;
`endif

endmodule

// File: tb/tb_fft_sched.sv
// tb_fft_sched: directed frame-table and sequence bench for fft_sched (N=64, PRIME=1, depth 8)
module tb_fft_sched;
   import fft_sched_pkg::*;

   localparam int W = 16;
   localparam int LOG2N = 6;
   localparam int N = 64;
`ifdef FFT_SCHED_STATS_EN
   localparam int EXP_S0 = 3, EXP_S1 = 2;
`else
   localparam int EXP_S0 = 0, EXP_S1 = 0;
`endif

   typedef struct {
      bit v0;
      bit v1;
      bit tog;
      int exp_id;
      int exp_span;
   } frame_t;

   logic clock = 1'b0, reset = 1'b1;
   logic s0_valid = 1'b0, s1_valid = 1'b0, fft_out_en = 1'b0;
   logic [W-1:0] s0_re = '0, s0_im = '0, s1_re = '0, s1_im = '0, fft_out_re = '0, fft_out_im = '0;
   logic s0_ready, s1_ready, fft_in_en, m_valid, m_id, m_last, busy;
   logic [W-1:0] fft_in_re, fft_in_im, m_re, m_im;
   logic [15:0] stat_frames0, stat_frames1;
   int vectors = 0, miscompares = 0, seq = 0;

   always #5 clock = ~clock;

   fft_sched #(.WIDTH(W), .LOG2N(LOG2N), .PRIME(1), .TAGQ_DEPTH(8)) dut (
      .clock(clock), .reset(reset),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_re(s0_re), .s0_im(s0_im),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_re(s1_re), .s1_im(s1_im),
      .fft_in_en(fft_in_en), .fft_in_re(fft_in_re), .fft_in_im(fft_in_im),
      .fft_out_en(fft_out_en), .fft_out_re(fft_out_re), .fft_out_im(fft_out_im),
      .m_valid(m_valid), .m_re(m_re), .m_im(m_im), .m_id(m_id), .m_last(m_last),
      .busy(busy), .stat_frames0(stat_frames0), .stat_frames1(stat_frames1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, want);
      end
   endtask

   task automatic do_reset();
      s0_valid = 1'b0;
      s1_valid = 1'b0;
      fft_out_en = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " control"}, {s0_ready, s1_ready, fft_in_en, m_valid, m_id, m_last, busy}, 0);
      check({tag, " fft_in data"}, {fft_in_re, fft_in_im}, 0);
      check({tag, " m data"}, {m_re, m_im}, 0);
   endtask

   // drive one input frame and check strobe count, owner, span, exclusive ready and sample data
   task automatic run_frame(input frame_t f, input string tag);
      logic [2*W-1:0] q[$];
      logic [2*W-1:0] want;
      int strobes = 0, cyc = 0, first = 0, last = 0, gid = -1, bad_rdy = 0, bad_data = 0;
      s0_valid = f.v0;
      s1_valid = f.v1;
      while (strobes < N && cyc < 400) begin
         @(negedge clock);
         cyc++;
         if (fft_in_en) begin
            if (strobes == 0) first = cyc;
            last = cyc;
            strobes++;
            want = q.size() > 0 ? q.pop_front() : '0;
            if ({fft_in_re, fft_in_im} !== want) bad_data++;
         end
         if (gid < 0 && (s0_ready || s1_ready)) gid = s1_ready ? 1 : 0;
         if ((s0_ready && gid != 0) || (s1_ready && gid != 1)) bad_rdy++;
         if (f.tog) s0_valid = ~s0_valid;
         seq++;
         s0_re = W'(seq);
         s0_im = ~W'(seq);
         s1_re = W'(seq * 3);
         s1_im = W'(seq + 7);
         if (s0_valid && s0_ready) q.push_back({s0_re, s0_im});
         if (s1_valid && s1_ready) q.push_back({s1_re, s1_im});
      end
      check({tag, " strobes"}, strobes, N);
      check({tag, " grant id"}, gid, f.exp_id);
      check({tag, " span"}, last - first + 1, f.exp_span);
      check({tag, " other ready"}, bad_rdy, 0);
      check({tag, " sample data"}, bad_data, 0);
   endtask

   // stream n_strobe pipeline outputs back to back and check the tagged result stream
   task automatic out_frame(input int n_strobe, input int exp_valid, input int exp_id, input int exp_last_at, input string tag);
      int nvalid = 0, nlast = 0, bad_last = 0, bad_id = 0, bad_data = 0;
      for (int i = 0; i <= n_strobe; i++) begin
         @(negedge clock);
         if (m_valid) begin
            nvalid++;
            if (m_id !== exp_id[0]) bad_id++;
            if (m_re !== fft_out_re || m_im !== fft_out_im) bad_data++;
         end
         if (m_last) begin
            nlast++;
            if (i - 1 != exp_last_at) bad_last++;
         end
         fft_out_en = i < n_strobe;
         fft_out_re = W'($urandom);
         fft_out_im = W'($urandom);
      end
      check({tag, " m_valid count"}, nvalid, exp_valid);
      check({tag, " m_last count"}, nlast, exp_last_at >= 0 ? 1 : 0);
      check({tag, " m_last position"}, bad_last, 0);
      check({tag, " m_id"}, bad_id, 0);
      check({tag, " m data"}, bad_data, 0);
   endtask

   task automatic full_block();
      int rdy = 0, en = 0;
      s0_valid = 1'b1;
      repeat (20) begin
         @(negedge clock);
         if (s0_ready) rdy++;
         if (fft_in_en) en++;
      end
      check("full queue ready", rdy, 0);
      check("full queue strobes", en, 0);
      check("full queue busy", busy, 1);
      s0_valid = 1'b0;
   endtask

   task automatic reset_mid_frame();
      frame_t f;
      int n = 0, cyc = 0;
      f = '{1'b1, 1'b1, 1'b0, 0, N};
      do_reset();
      run_frame(f, "pre-reset frame");
      s0_valid = 1'b1;
      s1_valid = 1'b1;
      while (n < 30 && cyc < 200) begin
         @(negedge clock);
         cyc++;
         if (fft_in_en) n++;
      end
      check("strobes before mid-frame reset", n, 30);
      reset = 1'b1;
      #1;
      check_quiet("mid-frame reset");
      @(negedge clock);
      check_quiet("mid-frame reset held");
      reset = 1'b0;
      run_frame(f, "post-reset frame");
      s0_valid = 1'b0;
      s1_valid = 1'b0;
   endtask

   task automatic solo_scenario();
      frame_t solo, flush;
      solo = '{1'b1, 1'b0, 1'b0, 0, N};
      flush = '{1'b0, 1'b0, 1'b0, -1, N};
      do_reset();
      run_frame(solo, "s0 solo");
      run_frame(flush, "s0 solo flush");
      repeat (420) @(negedge clock);
      check("stalled strobe", fft_in_en, 0);
      check("stalled busy", busy, 1);
      out_frame(N, 0, 0, -1, "priming frame");
      out_frame(N, N, 0, N - 1, "s0 result");
      for (int k = 0; k < 7; k++) out_frame(N, 0, 0, -1, "flush result");
      check("drained busy", busy, 0);
      out_frame(10, 0, 0, -1, "empty queue");
      run_frame(solo, "late s0");
      s0_valid = 1'b0;
      out_frame(N, N - 10, 0, N - 11, "late s0 result");
   endtask

   initial begin
      frame_t frames [7];
      frames[0] = '{1'b1, 1'b1, 1'b0, 0, N};
      frames[1] = '{1'b1, 1'b1, 1'b0, 1, N};
      frames[2] = '{1'b1, 1'b1, 1'b0, 0, N};
      frames[3] = '{1'b1, 1'b1, 1'b0, 1, N};
      frames[4] = '{1'b1, 1'b0, 1'b1, 0, 2 * N - 1};
      frames[5] = '{1'b0, 1'b0, 1'b0, -1, N};
      frames[6] = '{1'b0, 1'b0, 1'b0, -1, N};
      do_reset();
      check_quiet("reset");
      check("reset stat_frames0", stat_frames0, 0);
      check("reset stat_frames1", stat_frames1, 0);
      for (int i = 0; i < 7; i++) run_frame(frames[i], $sformatf("frame %0d", i));
      check("stat_frames0", stat_frames0, EXP_S0);
      check("stat_frames1", stat_frames1, EXP_S1);
      full_block();
      reset_mid_frame();
      solo_scenario();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
